fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the pipelined MIPS core: owns the PC, issues instruction reads to the icache, and presents one fetched instruction per cycle to the fetch/decode latch. A one-entry hold buffer absorbs an icache hit that lands while the downstream stage is stalled. Redirects from branch/jump resolution override everything and squash any in-flight or held instruction.

## Interface
- PC_INIT, 32'h0000_0000, PC loaded on reset
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- imemREN  out  1  icache read request
- imemaddr  out  32  icache word address (always PC, low 2 bits 0)
- ihit  in  1  icache hit; imemload valid this cycle
- imemload  in  32  instruction returned by icache
- en  in  1  downstream accept (fetch latch enable from hazard unit)
- redirect  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  new PC; low 2 bits ignored (forced 0)
- valid  out  1  instr/pc/pc_plus_4 hold a real instruction this cycle
- instr  out  32  fetched instruction
- pc  out  32  address of instr
- pc_plus_4  out  32  pc + 4, mod 2^32
- halted  out  1  fetch stopped on halt (0 when FETCH_HALT_DETECT_EN undefined)

## Operation
- States: FETCH, HOLD, HALTED (HALTED exists only with macro).
- FETCH: imemREN=1, imemaddr=PC. valid=ihit; instr=imemload (bypass, no register).
  - ihit & en: transfer; PC <= PC+4; stay FETCH.
  - ihit & !en: capture imemload into hold register; -> HOLD.
  - !ihit: stay, request held stable.
- HOLD: imemREN=0; valid=1; instr=hold register; pc=PC.
  - en: transfer; PC <= PC+4; -> FETCH.
  - !en: stay, outputs stable.
- HALTED: imemREN=0, valid=0, halted=1. Only exits via redirect or RST.
- redirect (any state) has priority: valid forced 0 that cycle, no transfer, PC <= {redirect_pc[31:2],2'b00}, hold register discarded, -> FETCH. Applies even when ihit & en same cycle.
- Transfer = valid & en & !redirect.
- PC arithmetic 32-bit unsigned, wraps 32'hFFFF_FFFC -> 0.

## Timing
- RST high at edge: PC=PC_INIT, state FETCH, hold=0. During RST cycle outputs: imemREN=0, valid=0, instr=0, pc=0, pc_plus_4=0, halted=0.
- First request cycle after RST deasserts.
- Zero-wait icache: one instruction per cycle, valid same cycle as ihit.
- HOLD -> FETCH costs no bubble beyond the stall itself; new request issued the cycle after HOLD transfer.
- Redirect: new address on imemaddr the cycle after redirect asserted; one-cycle bubble minimum.
- RST mid-HOLD or mid-request: held instruction dropped, no transfer.

## Configuration
- FETCH_HALT_DETECT_EN defined: transfer of instr == 32'hFFFF_FFFF (halt) delivers the halt downstream, then -> HALTED; no further imemREN. Redirect in HALTED (older branch squashing the halt) returns to FETCH.
- Undefined: halt opcode treated as ordinary instruction, fetch continues at PC+4; halted tied 0; HALTED state not compiled.

## Structure
- cpu_types_pkg gains: word_t (32-bit) if absent, HALT_INSTR constant 32'hFFFF_FFFF, fetch_state_t enum {FETCH, HOLD, HALTED}.
- Sub-module fetch_skid_buf: one-entry hold register (load, clear, data out); top owns FSM and PC.

## Test plan
- RST 2 cycles, PC_INIT=0, ihit=1, en=1 -> imemaddr 0,4,8,... one per cycle, valid=1 each, pc_plus_4 = pc+4.
- At PC=0x10 ihit=1, en=0 for 3 cycles -> HOLD, imemREN=0, instr stable = captured 0x10 word; en=1 -> transfer, next imemaddr 0x14.
- ihit=1, en=1, redirect=1, redirect_pc=0x203 -> valid=0 that cycle, next imemaddr 0x200, no transfer of old instr.
- Redirect in HOLD -> hold dropped, next cycle imemaddr=redirect_pc, valid follows ihit.
- PC=0xFFFF_FFFC transfer -> pc_plus_4=0, next imemaddr 0.
- Macro on: imemload=0xFFFF_FFFF transferred -> halted=1, imemREN=0 thereafter; redirect to 0x40 -> FETCH at 0x40. Macro off: same stimulus -> fetch continues at PC+4, halted=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, halt encoding and fetch-stage state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  localparam word_t HALT_INSTR = 32'hFFFF_FFFF;
  localparam word_t WORD_ALIGN = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry hold register that parks an icache hit while decode is stalled.
module fetch_skid_buf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  load,
  input  logic  clear,
  input  word_t din,
  output word_t dout
);
  word_t data_q;

  // Clear wins over load so a redirect always drops the parked word.
  always_ff @(posedge CLK) begin
    if (RST || clear) data_q <= '0;
    else if (load)    data_q <= din;
  end

  assign dout = data_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, icache request, one-entry stall buffer and redirect handling.
// Optional halt detection is compiled in with `define FETCH_HALT_DETECT_EN.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  ihit,
  input  word_t imemload,
  input  logic  en,
  input  logic  redirect,
  input  word_t redirect_pc,
  output logic  valid,
  output word_t instr,
  output word_t pc,
  output word_t pc_plus_4,
  output logic  halted
);
  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d, hold_q, cur_instr;
  logic         hold_load, hold_clr, cur_valid, xfer;

  fetch_skid_buf u_hold (
    .CLK   (CLK),
    .RST   (RST),
    .load  (hold_load),
    .clear (hold_clr),
    .din   (imemload),
    .dout  (hold_q)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    imemREN   = 1'b0;
    cur_valid = 1'b0;
    cur_instr = '0;
    halted    = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;

    case (state_q)
      FETCH: begin
        imemREN   = 1'b1;
        cur_valid = ihit;
        cur_instr = imemload;
        if (ihit && !en && !redirect) begin
          hold_load = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        cur_valid = 1'b1;
        cur_instr = hold_q;
      end
`ifdef FETCH_HALT_DETECT_EN
      HALTED: halted = 1'b1;
`endif
      default: ;
    endcase

    xfer = cur_valid && en && !redirect;
    if (xfer) begin
      pc_d    = pc_q + 32'd4;
      state_d = FETCH;
`ifdef FETCH_HALT_DETECT_EN
      if (cur_instr == HALT_INSTR) state_d = HALTED;
`endif
    end

    // Redirect squashes whatever is in flight or parked.
    if (redirect) begin
      cur_valid = 1'b0;
      pc_d      = redirect_pc & WORD_ALIGN;
      state_d   = FETCH;
      hold_clr  = 1'b1;
    end

    valid = cur_valid;
    instr = cur_instr;
    if (RST) begin
      imemREN = 1'b0;
      valid   = 1'b0;
      instr   = '0;
      halted  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imemaddr  = pc_q;
  assign pc        = RST ? '0 : pc_q;
  assign pc_plus_4 = RST ? '0 : pc_q + 32'd4;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected transfers, a monitor pops and checks.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST, imemREN, ihit, en, redirect, valid, halted;
  word_t imemaddr, imemload, redirect_pc, instr, pc, pc_plus_4;

  int tests = 0;
  int fails = 0;

  typedef struct packed { word_t pc; word_t instr; } xfer_t;
  xfer_t exp_q[$];

  fetch_unit #(.PC_INIT(32'h0)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .en(en), .redirect(redirect),
    .redirect_pc(redirect_pc), .valid(valid), .instr(instr), .pc(pc),
    .pc_plus_4(pc_plus_4), .halted(halted)
  );

  always #5 CLK = ~CLK;

  function automatic word_t mem(input word_t a);
    if (a == 32'h80) return 32'hFFFF_FFFF;
    return a ^ 32'h1234_5678;
  endfunction

  always_comb imemload = imemREN ? mem(imemaddr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input word_t act, input word_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input word_t p);
    xfer_t x;
    x.pc = p;
    x.instr = mem(p);
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic h, input logic e, input logic r, input word_t rp);
    ihit = h; en = e; redirect = r; redirect_pc = rp;
    #2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every observed transfer must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && valid && en && !redirect) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL xfer_unexpected: got pc %h instr %h, none expected", pc, instr);
      end else begin
        xfer_t x;
        x = exp_q.pop_front();
        chk("xfer_pc", pc, x.pc);
        chk("xfer_instr", instr, x.instr);
        chk("xfer_pc4", pc_plus_4, x.pc + 32'd4);
      end
    end
  end

  initial begin
    RST = 1'b1;
    ihit = 1'b0; en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
    drive(1, 1, 0, 0);
    chk("rst_ren", {31'b0, imemREN}, 0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_pc4", pc_plus_4, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    tick();
    RST = 1'b0;

    // Streaming one instruction per cycle from PC_INIT.
    for (int i = 0; i < 4; i++) begin
      push(32'(i * 4));
      drive(1, 1, 0, 0);
      chk("stream_addr", imemaddr, 32'(i * 4));
      chk("stream_ren", {31'b0, imemREN}, 1);
      tick();
    end

    // Stall at 0x10: capture, hold stable, then release.
    drive(1, 0, 0, 0);
    chk("cap_valid", {31'b0, valid}, 1);
    chk("cap_addr", imemaddr, 32'h10);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0);
      chk("hold_ren", {31'b0, imemREN}, 0);
      chk("hold_valid", {31'b0, valid}, 1);
      chk("hold_instr", instr, mem(32'h10));
      chk("hold_pc", pc, 32'h10);
      tick();
    end
    push(32'h10);
    drive(0, 1, 0, 0);
    tick();
    drive(1, 1, 0, 0);
    chk("post_hold_addr", imemaddr, 32'h14);
    push(32'h14);
    tick();

    // Redirect beats a same-cycle hit+accept.
    drive(1, 1, 1, 32'h203);
    chk("redir_valid", {31'b0, valid}, 0);
    tick();
    push(32'h200);
    drive(1, 1, 0, 0);
    chk("redir_addr", imemaddr, 32'h200);
    tick();

    // Miss keeps the request stable.
    drive(0, 1, 0, 0);
    chk("miss_valid", {31'b0, valid}, 0);
    chk("miss_addr", imemaddr, 32'h204);
    tick();
    drive(1, 0, 0, 0);
    chk("miss_addr2", imemaddr, 32'h204);
    tick();

    // Redirect while holding drops the held word.
    drive(0, 1, 1, 32'h300);
    chk("hold_redir_valid", {31'b0, valid}, 0);
    tick();
    drive(0, 1, 0, 0);
    chk("hold_redir_addr", imemaddr, 32'h300);
    chk("hold_redir_ren", {31'b0, imemREN}, 1);
    chk("hold_redir_miss", {31'b0, valid}, 0);
    tick();
    push(32'h300);
    drive(1, 1, 0, 0);
    tick();

    // PC wraparound.
    drive(0, 0, 1, 32'hFFFF_FFFF);
    tick();
    push(32'hFFFF_FFFC);
    drive(1, 1, 0, 0);
    chk("wrap_pc4", pc_plus_4, 32'h0);
    tick();
    drive(1, 1, 0, 0);
    chk("wrap_addr", imemaddr, 32'h0);
    push(32'h0);
    tick();

    // Halt opcode at 0x80.
    drive(0, 0, 1, 32'h80);
    tick();
    push(32'h80);
    drive(1, 1, 0, 0);
    tick();
`ifdef FETCH_HALT_DETECT_EN
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0);
      chk("halt_flag", {31'b0, halted}, 1);
      chk("halt_ren", {31'b0, imemREN}, 0);
      chk("halt_valid", {31'b0, valid}, 0);
      tick();
    end
`else
    drive(1, 1, 0, 0);
    chk("nohalt_flag", {31'b0, halted}, 0);
    chk("nohalt_addr", imemaddr, 32'h84);
    chk("nohalt_ren", {31'b0, imemREN}, 1);
    push(32'h84);
    tick();
`endif
    drive(0, 0, 1, 32'h40);
    tick();
    drive(1, 1, 0, 0);
    chk("resume_addr", imemaddr, 32'h40);
    chk("resume_halted", {31'b0, halted}, 0);
    push(32'h40);
    tick();

    // Reset mid-hold: held word is dropped, PC returns to PC_INIT.
    drive(1, 0, 0, 0);
    tick();
    RST = 1'b1;
    drive(0, 1, 0, 0);
    chk("rst_hold_valid", {31'b0, valid}, 0);
    tick();
    RST = 1'b0;
    drive(1, 1, 0, 0);
    chk("rst_hold_addr", imemaddr, 32'h0);
    chk("rst_hold_ren", {31'b0, imemREN}, 1);
    push(32'h0);
    tick();

    drive(0, 0, 0, 0);
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_xfers: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
